branch_resolution_queue: RTL and testbench
==========================================

BRANCH_RESOLUTION_QUEUE -- requirements
Module: branch_resolution_queue

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 1, width of the branch address carried per entry.
REQ-002 SHALL have parameter DEPTH_LOG2, default 2, log2 of queue depth (depth = 2**DEPTH_LOG2).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port push_valid  input  1  new predicted branch offered.
REQ-006 SHALL have port push_ready  output  1  queue can accept an entry.
REQ-007 SHALL have port push_address  input  ADDRESS_WIDTH  address of the predicted branch.
REQ-008 SHALL have port push_prediction  input  1  direction predicted at fetch.
REQ-009 SHALL have port resolve_valid  input  1  oldest outstanding branch resolved this cycle.
REQ-010 SHALL have port resolve_taken  input  1  actual outcome of that branch.
REQ-011 SHALL have port upd_enable  output  1  one-cycle predictor training strobe (drives predictor cs and enable).
REQ-012 SHALL have port upd_address  output  ADDRESS_WIDTH  address to train.
REQ-013 SHALL have port upd_result  output  1  outcome to train with.
REQ-014 SHALL have port mispredict  output  1  one-cycle pulse, resolved outcome differed from stored prediction.
REQ-015 SHALL have port count  output  DEPTH_LOG2+1  current occupancy.

Function
REQ-016 SHALL hold entries {address, prediction} in FIFO order; push accepted on rising edge when push_valid && push_ready.
REQ-017 SHALL drive push_ready = (count != depth), combinational from state only; no same-cycle pop bypass.
REQ-018 SHALL pop the oldest entry on rising edge when resolve_valid && count != 0; resolve_valid with count == 0 ignored, no outputs pulse.
REQ-019 SHALL register outputs: cycle after an accepted resolve, upd_enable = 1, upd_address = popped address, upd_result = resolve_taken; otherwise upd_enable = 0 and upd_address/upd_result hold last values.
REQ-020 SHALL assert mispredict in the same cycle as upd_enable when popped prediction != resolve_taken.
REQ-021 SHALL, on accepted resolve that mispredicts, empty the queue at that edge (younger entries are wrong-path); a push in the same cycle is discarded.
REQ-022 SHALL, on simultaneous accepted push and correct resolve, keep count unchanged and store the pushed entry.
REQ-023 SHALL wrap read/write pointers modulo depth; count is exact 0..depth.
REQ-024 SHALL not allow push into a just-emptied entry to be visible to resolve in the same cycle (push on empty + resolve_valid: resolve ignored).

Reset
REQ-025 SHALL on rst: count = 0, pointers = 0, push_ready = 1, upd_enable = 0, mispredict = 0, upd_address = 0, upd_result = 0; rst overrides push and resolve in the same cycle.
REQ-026 SHALL not require storage array clearing; entries beyond count are don't-care.

Configuration
REQ-027 SHALL support macro BRQ_STATS_EN.
REQ-028 With BRQ_STATS_EN defined: SHALL add outputs resolved_count (16) and mispredict_count (16), each incrementing on accepted resolve / mispredict, saturating at 16'hFFFF, cleared by rst.
REQ-029 Without BRQ_STATS_EN: those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-030 SHALL take default ADDRESS_WIDTH, DEPTH_LOG2 and stats counter width (16) from shared package bp_pkg, also used by the predictor.
REQ-031 SHALL place entry storage and pointers in sub-module brq_storage (write port, read-at-head port); control, flush and output registers stay in the top.

Verification
REQ-032 Reset then idle: count = 0, push_ready = 1, upd_enable = 0 for 5 cycles.
REQ-033 ADDRESS_WIDTH=4, DEPTH_LOG2=2: push (3,1),(5,0),(9,1),(2,0) -> count = 4, push_ready = 0; fifth push ignored, count stays 4.
REQ-034 Resolve taken=1, then 0, with entries (3,1),(5,0) -> upd_enable pulses with (3,1) then (5,0), mispredict = 0 both, count 2 -> 0.
REQ-035 Entries (3,1),(5,0),(9,1); resolve taken=0 with push (7,1) same cycle -> next cycle upd=(3,0), mispredict = 1, count = 0, (7,1) discarded.
REQ-036 Count = 2, simultaneous push (6,1) and correct resolve -> count stays 2; pointers wrap after 8 such cycles, FIFO order preserved.
REQ-037 BRQ_STATS_EN, 70000 mispredicting resolves -> mispredict_count = 16'hFFFF, resolved_count = 16'hFFFF; rst mid-stream clears counters and queue.

Source files
------------

// File: rtl/bp_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | bp_pkg : shared defaults for the branch predictor and resolution queue. |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
package bp_pkg;

  localparam int BP_ADDRESS_WIDTH = 1;
  localparam int BP_DEPTH_LOG2    = 2;
  localparam int BP_STATS_WIDTH   = 16;

  // Statistics counters stick at all-ones rather than wrapping.
  function automatic logic [BP_STATS_WIDTH-1:0] sat_inc(input logic [BP_STATS_WIDTH-1:0] v);
    return (v == {BP_STATS_WIDTH{1'b1}}) ? v : v + BP_STATS_WIDTH'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/brq_storage.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | brq_storage : circular entry store with write port and head read port.  |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
module brq_storage
  import bp_pkg::*;
#(
  parameter int ADDRESS_WIDTH = BP_ADDRESS_WIDTH,
  parameter int DEPTH_LOG2    = BP_DEPTH_LOG2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_address,
  input  logic                     wr_prediction,
  input  logic                     rd_en,
  output logic [ADDRESS_WIDTH-1:0] rd_address,
  output logic                     rd_prediction
);

  localparam int c_depth = 1 << DEPTH_LOG2;

  logic [ADDRESS_WIDTH-1:0] r_mem_address    [c_depth];
  logic                     r_mem_prediction [c_depth];
  logic [DEPTH_LOG2-1:0]    r_wr_ptr;
  logic [DEPTH_LOG2-1:0]    r_rd_ptr;

  // Pointers are exactly DEPTH_LOG2 wide, so increment wraps modulo depth.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (wr_en) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (rd_en) r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem_address[r_wr_ptr]    <= wr_address;
      r_mem_prediction[r_wr_ptr] <= wr_prediction;
    end
  end

  assign rd_address    = r_mem_address[r_rd_ptr];
  assign rd_prediction = r_mem_prediction[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/branch_resolution_queue.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | branch_resolution_queue : in-order queue of predicted branches; trains  |
// | the predictor on resolve and flushes on mispredict.                     |
// | Optional statistics counters enabled by macro BRQ_STATS_EN.             |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
module branch_resolution_queue
  import bp_pkg::*;
#(
  parameter int ADDRESS_WIDTH = BP_ADDRESS_WIDTH,
  parameter int DEPTH_LOG2    = BP_DEPTH_LOG2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [ADDRESS_WIDTH-1:0] push_address,
  input  logic                     push_prediction,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     upd_enable,
  output logic [ADDRESS_WIDTH-1:0] upd_address,
  output logic                     upd_result,
  output logic                     mispredict,
  output logic [DEPTH_LOG2:0]      count
`ifdef BRQ_STATS_EN
  ,
  output logic [BP_STATS_WIDTH-1:0] resolved_count,
  output logic [BP_STATS_WIDTH-1:0] mispredict_count
`endif
);

  localparam logic [DEPTH_LOG2:0] c_depth = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

  logic [DEPTH_LOG2:0]      r_count;
  logic                     r_upd_enable;
  logic [ADDRESS_WIDTH-1:0] r_upd_address;
  logic                     r_upd_result;
  logic                     r_mispredict;

  logic                     w_push;
  logic                     w_pop;
  logic                     w_flush;
  logic [ADDRESS_WIDTH-1:0] w_head_address;
  logic                     w_head_prediction;

  assign push_ready = (r_count != c_depth);
  assign w_push     = push_valid && push_ready;
  // An entry written this cycle is not yet countable, so an empty queue ignores resolve.
  assign w_pop      = resolve_valid && (r_count != '0);
  assign w_flush    = w_pop && (w_head_prediction != resolve_taken);

  brq_storage #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DEPTH_LOG2    (DEPTH_LOG2)
  ) u_storage (
    .clk           (clk),
    .rst           (rst),
    .flush         (w_flush),
    .wr_en         (w_push && !w_flush),
    .wr_address    (push_address),
    .wr_prediction (push_prediction),
    .rd_en         (w_pop && !w_flush),
    .rd_address    (w_head_address),
    .rd_prediction (w_head_prediction)
  );

  // Mispredict drops every younger entry, including one offered this cycle.
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + (DEPTH_LOG2+1)'(w_push) - (DEPTH_LOG2+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_upd_enable  <= 1'b0;
      r_upd_address <= '0;
      r_upd_result  <= 1'b0;
      r_mispredict  <= 1'b0;
    end else begin
      r_upd_enable <= w_pop;
      r_mispredict <= w_flush;
      if (w_pop) begin
        r_upd_address <= w_head_address;
        r_upd_result  <= resolve_taken;
      end
    end
  end

  assign count       = r_count;
  assign upd_enable  = r_upd_enable;
  assign upd_address = r_upd_address;
  assign upd_result  = r_upd_result;
  assign mispredict  = r_mispredict;

`ifdef BRQ_STATS_EN
  logic [BP_STATS_WIDTH-1:0] r_resolved_count;
  logic [BP_STATS_WIDTH-1:0] r_mispredict_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resolved_count   <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_pop)   r_resolved_count   <= sat_inc(r_resolved_count);
      if (w_flush) r_mispredict_count <= sat_inc(r_mispredict_count);
    end
  end

  assign resolved_count   = r_resolved_count;
  assign mispredict_count = r_mispredict_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolution_queue.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_branch_resolution_queue : directed and random checks vs. queue model.|
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
module tb_branch_resolution_queue;

  localparam int AW    = 4;
  localparam int DL2   = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push_valid = 1'b0;
  logic          push_ready;
  logic [AW-1:0] push_address = '0;
  logic          push_prediction = 1'b0;
  logic          resolve_valid = 1'b0;
  logic          resolve_taken = 1'b0;
  logic          upd_enable;
  logic [AW-1:0] upd_address;
  logic          upd_result;
  logic          mispredict;
  logic [DL2:0]  count;
`ifdef BRQ_STATS_EN
  logic [15:0]   resolved_count;
  logic [15:0]   mispredict_count;
`endif

  always #5 clk = ~clk;

  branch_resolution_queue #(
    .ADDRESS_WIDTH (AW),
    .DEPTH_LOG2    (DL2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .push_valid      (push_valid),
    .push_ready      (push_ready),
    .push_address    (push_address),
    .push_prediction (push_prediction),
    .resolve_valid   (resolve_valid),
    .resolve_taken   (resolve_taken),
    .upd_enable      (upd_enable),
    .upd_address     (upd_address),
    .upd_result      (upd_result),
    .mispredict      (mispredict),
    .count           (count)
`ifdef BRQ_STATS_EN
    ,
    .resolved_count   (resolved_count),
    .mispredict_count (mispredict_count)
`endif
  );

  typedef struct {
    logic [AW-1:0] a;
    logic          p;
  } ent_t;

  ent_t          mq[$];
  logic          m_en = 1'b0;
  logic          m_mis = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic          m_res = 1'b0;
  int            m_rc = 0;
  int            m_mc = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check state-derived outputs, advance model, check registered outputs.
  task automatic cyc(input logic r, input logic pv, input logic [AW-1:0] pa, input logic pp,
                     input logic rv, input logic rt);
    bit   acc_push, acc_pop;
    ent_t e;
    rst = r; push_valid = pv; push_address = pa; push_prediction = pp;
    resolve_valid = rv; resolve_taken = rt;
    if (!r) begin
      check("push_ready", 32'(push_ready), 32'(mq.size() != DEPTH));
      check("count_pre", 32'(count), 32'(mq.size()));
    end
    @(posedge clk);
    if (r) begin
      mq.delete(); m_en = 0; m_mis = 0; m_addr = '0; m_res = 0; m_rc = 0; m_mc = 0;
    end else begin
      acc_push = pv && (mq.size() < DEPTH);
      acc_pop  = rv && (mq.size() > 0);
      m_en = acc_pop; m_mis = 0;
      if (acc_pop) begin
        e = mq.pop_front();
        m_addr = e.a; m_res = rt; m_mis = (e.p != rt);
        if (m_rc < 65535) m_rc++;
        if (m_mis) begin
          mq.delete();
          if (m_mc < 65535) m_mc++;
        end
      end
      if (acc_push && !m_mis) mq.push_back('{a: pa, p: pp});
    end
    #1;
    check("upd_enable", 32'(upd_enable), 32'(m_en));
    check("mispredict", 32'(mispredict), 32'(m_mis));
    check("upd_address", 32'(upd_address), 32'(m_addr));
    check("upd_result", 32'(upd_result), 32'(m_res));
    check("count", 32'(count), 32'(mq.size()));
`ifdef BRQ_STATS_EN
    check("resolved_count", 32'(resolved_count), 32'(m_rc));
    check("mispredict_count", 32'(mispredict_count), 32'(m_mc));
`endif
  endtask

  task automatic push(input logic [AW-1:0] a, input logic p);
    cyc(0, 1, a, p, 0, 0);
  endtask

  task automatic resolve(input logic t);
    cyc(0, 0, '0, 0, 1, t);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic          head_p;
    @(posedge clk); #1;
    cyc(1, 0, '0, 0, 0, 0);
    cyc(1, 1, 4'h5, 1, 1, 0);
    // Idle after reset
    for (int i = 0; i < 5; i++) cyc(0, 0, '0, 0, 0, 0);
    check("idle_count", 32'(count), 32'd0);
    check("idle_ready", 32'(push_ready), 32'd1);

    // Fill to depth; fifth push must be refused
    push(4'd3, 1); push(4'd5, 0); push(4'd9, 1); push(4'd2, 0);
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(push_ready), 32'd0);
    push(4'd8, 1);
    check("full_count_hold", 32'(count), 32'd4);

    // Two correct resolves drain two entries
    cyc(1, 0, '0, 0, 0, 0);
    push(4'd3, 1); push(4'd5, 0);
    resolve(1);
    check("res1_addr", 32'(upd_address), 32'd3);
    resolve(0);
    check("res2_addr", 32'(upd_address), 32'd5);
    check("res2_mis", 32'(mispredict), 32'd0);
    check("res2_count", 32'(count), 32'd0);
    resolve(1);

    // Mispredict flushes and drops the same-cycle push
    push(4'd3, 1); push(4'd5, 0); push(4'd9, 1);
    cyc(0, 1, 4'd7, 1, 1, 0);
    check("flush_addr", 32'(upd_address), 32'd3);
    check("flush_res", 32'(upd_result), 32'd0);
    check("flush_mis", 32'(mispredict), 32'd1);
    check("flush_count", 32'(count), 32'd0);
    cyc(0, 0, '0, 0, 0, 0);

    // Push on empty with resolve: resolve ignored
    cyc(0, 1, 4'd4, 1, 1, 1);
    check("empty_res_en", 32'(upd_enable), 32'd0);
    check("empty_res_count", 32'(count), 32'd1);

    // Steady state push+correct resolve wraps pointers
    push(4'd11, 0);
    for (int i = 0; i < 8; i++) begin
      head_p = mq[0].p;
      cyc(0, 1, AW'(i + 6), 1, 1, head_p);
      check("wrap_count", 32'(count), 32'd2);
    end
    resolve(mq[0].p);
    check("wrap_order", 32'(upd_address), 32'd12);

    // Random traffic, mostly correct resolves
    for (int i = 0; i < 3000; i++) begin
      ra = AW'($urandom);
      head_p = (mq.size() > 0) ? mq[0].p : 1'b0;
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 6), ra, 1'($urandom),
          ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 4) == 0) ? ~head_p : head_p);
    end

`ifdef BRQ_STATS_EN
    cyc(1, 0, '0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) begin
      push(AW'(i), 1);
      resolve(0);
    end
    check("sat_resolved", 32'(resolved_count), 32'hFFFF);
    check("sat_mispredict", 32'(mispredict_count), 32'hFFFF);
    push(4'd1, 1);
    cyc(1, 1, 4'd2, 0, 1, 0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_resolved", 32'(resolved_count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
